// File: rtl/ibp_setassoc.sv
// rtl/ibp_setassoc.sv - set-associative indirect branch target predictor
// Path-history indexed table with partial tags, hysteresis confidence and one-cycle registered lookup.
module ibp_setassoc #(
    parameter int SETS      = 128,
    parameter int WAYS      = 4,
    parameter int TAG_BITS  = 16,
    parameter int CONF_BITS = 2,
    localparam int IDX_BITS = $clog2(SETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_valid_i,
    input  logic [63:0]         lookup_pc_i,
    output logic                pred_valid_o,
    output logic                pred_hit_o,
    output logic [63:0]         pred_target_o,
    output logic [IDX_BITS-1:0] pred_hist_o,
    input  logic                update_valid_i,
    input  logic [63:0]         update_pc_i,
    input  logic [63:0]         update_target_i,
    input  logic [IDX_BITS-1:0] update_hist_i
);
    localparam int PC_HI = 2 + IDX_BITS + TAG_BITS;
    typedef logic [CONF_BITS-1:0] conf_t;
    localparam conf_t CONF_MAX = '1;
    localparam conf_t CONF_ONE = conf_t'(1);

    logic                valid_q  [SETS][WAYS];
    logic [TAG_BITS-1:0] tag_q    [SETS][WAYS];
    logic [63:0]         target_q [SETS][WAYS];
    conf_t               conf_q   [SETS][WAYS];

    logic [IDX_BITS-1:0] hist_q, hist_d;
    logic                pred_valid_q, pred_valid_d;
    logic                pred_hit_q, pred_hit_d;
    logic [63:0]         pred_target_q, pred_target_d;
    logic [IDX_BITS-1:0] pred_hist_q, pred_hist_d;

    logic [IDX_BITS-1:0] lk_set, up_set;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic                lk_hit, up_hit, vic_found;
    logic [63:0]         lk_target;
    logic                up_match [WAYS];
    logic                vic_sel  [WAYS];

    logic                entry_valid_d  [WAYS];
    logic [TAG_BITS-1:0] entry_tag_d    [WAYS];
    logic [63:0]         entry_target_d [WAYS];
    conf_t               entry_conf_d   [WAYS];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[63:PC_HI], lookup_pc_i[1:0],
                              update_pc_i[63:PC_HI], update_pc_i[1:0]};

    // Lookup reads the table combinationally; the result is registered below.
    always_comb begin
        lk_set    = lookup_pc_i[2 +: IDX_BITS] ^ hist_q;
        lk_tag    = lookup_pc_i[2 + IDX_BITS +: TAG_BITS];
        lk_hit    = 1'b0;
        lk_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
                lk_hit    = 1'b1;
                lk_target = target_q[lk_set][w];
            end
        end
        pred_valid_d  = lookup_valid_i;
        pred_hit_d    = pred_hit_q;
        pred_target_d = pred_target_q;
        pred_hist_d   = pred_hist_q;
        if (lookup_valid_i) begin
            pred_hit_d    = lk_hit;
            pred_target_d = lk_target;
            pred_hist_d   = hist_q;
        end
        hist_d = hist_q;
        if (update_valid_i) begin
            hist_d = (hist_q << 1) ^ update_target_i[2 +: IDX_BITS];
        end
    end

    // Next contents of every way in the addressed set; written back only on update.
    always_comb begin
        up_set    = update_pc_i[2 +: IDX_BITS] ^ update_hist_i;
        up_tag    = update_pc_i[2 + IDX_BITS +: TAG_BITS];
        up_hit    = 1'b0;
        vic_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            entry_valid_d[w]  = valid_q[up_set][w];
            entry_tag_d[w]    = tag_q[up_set][w];
            entry_target_d[w] = target_q[up_set][w];
            entry_conf_d[w]   = conf_q[up_set][w];
            up_match[w]       = valid_q[up_set][w] && tag_q[up_set][w] == up_tag;
            vic_sel[w]        = 1'b0;
            if (up_match[w]) up_hit = 1'b1;
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[up_set][w]) begin
                vic_sel[w] = 1'b1;
                vic_found  = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && conf_q[up_set][w] == '0) begin
                vic_sel[w] = 1'b1;
                vic_found  = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (up_hit) begin
                if (up_match[w]) begin
                    if (target_q[up_set][w] == update_target_i) begin
                        if (conf_q[up_set][w] != CONF_MAX) entry_conf_d[w] = conf_q[up_set][w] + CONF_ONE;
                    end else if (conf_q[up_set][w] == '0) begin
                        entry_target_d[w] = update_target_i;
                        entry_conf_d[w]   = CONF_ONE;
                    end else begin
                        entry_conf_d[w] = conf_q[up_set][w] - CONF_ONE;
                    end
                end
            end else if (vic_found) begin
                if (vic_sel[w]) begin
                    entry_valid_d[w]  = 1'b1;
                    entry_tag_d[w]    = up_tag;
                    entry_target_d[w] = update_target_i;
                    entry_conf_d[w]   = CONF_ONE;
                end
            end else if (conf_q[up_set][w] != '0) begin
                entry_conf_d[w] = conf_q[up_set][w] - CONF_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    conf_q[s][w]  <= '0;
                end
            end
        end else if (update_valid_i) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[up_set][w] <= entry_valid_d[w];
                conf_q[up_set][w]  <= entry_conf_d[w];
            end
        end
    end

    // Tags and targets are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (update_valid_i) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_q[up_set][w]    <= entry_tag_d[w];
                target_q[up_set][w] <= entry_target_d[w];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q        <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_target_q <= '0;
            pred_hist_q   <= '0;
        end else begin
            hist_q        <= hist_d;
            pred_valid_q  <= pred_valid_d;
            pred_hit_q    <= pred_hit_d;
            pred_target_q <= pred_target_d;
            pred_hist_q   <= pred_hist_d;
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_hit_o    = pred_hit_q;
    assign pred_target_o = pred_target_q;
    assign pred_hist_o   = pred_hist_q;
endmodule

// File: tb/tb_ibp_setassoc.sv
// tb/tb_ibp_setassoc.sv - self-checking bench for ibp_setassoc
module tb_ibp_setassoc;
    logic        clk;
    logic        rst;
    logic        lookup_valid_i;
    logic [63:0] lookup_pc_i;
    logic        pred_valid_o;
    logic        pred_hit_o;
    logic [63:0] pred_target_o;
    logic [6:0]  pred_hist_o;
    logic        update_valid_i;
    logic [63:0] update_pc_i;
    logic [63:0] update_target_i;
    logic [6:0]  update_hist_i;

    int checks = 0;
    int failures = 0;

    ibp_setassoc #(.SETS(128), .WAYS(4), .TAG_BITS(16), .CONF_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
        .pred_valid_o(pred_valid_o), .pred_hit_o(pred_hit_o),
        .pred_target_o(pred_target_o), .pred_hist_o(pred_hist_o),
        .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
        .update_target_i(update_target_i), .update_hist_i(update_hist_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        uv;
        logic [63:0] upc;
        logic [63:0] utgt;
        logic [6:0]  uh;
        logic        lv;
        logic [63:0] lpc;
        logic        ehit;
        logic [63:0] etgt;
        logic [6:0]  ehist;
    } vec_t;

    typedef struct {
        int          id;
        logic        hit;
        logic [63:0] tgt;
        logic [6:0]  hist;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   next_id = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic add(input logic uv, input logic [63:0] upc, input logic [63:0] utgt, input logic [6:0] uh,
                       input logic lv, input logic [63:0] lpc,
                       input logic ehit, input logic [63:0] etgt, input logic [6:0] ehist);
        vec_t v;
        v.uv = uv; v.upc = upc; v.utgt = utgt; v.uh = uh;
        v.lv = lv; v.lpc = lpc; v.ehit = ehit; v.etgt = etgt; v.ehist = ehist;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        update_valid_i  = v.uv;
        update_pc_i     = v.uv ? v.upc : 64'hdead_beef_0bad_f00d;
        update_target_i = v.uv ? v.utgt : 64'h1234_5678_9abc_def0;
        update_hist_i   = v.uv ? v.uh : 7'h55;
        lookup_valid_i  = v.lv;
        lookup_pc_i     = v.lv ? v.lpc : 64'hffff_0000_ffff_0000;
        if (v.lv) begin
            e.id = next_id; e.hit = v.ehit; e.tgt = v.etgt; e.hist = v.ehist;
            next_id++;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        vec_t v;
        v.uv = 1'b0; v.upc = '0; v.utgt = '0; v.uh = '0;
        v.lv = 1'b0; v.lpc = '0; v.ehit = 1'b0; v.etgt = '0; v.ehist = '0;
        drive(v);
    endtask

    always @(negedge clk) begin
        if (pred_valid_o) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pred_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk($sformatf("pred_hit[%0d]", e.id), {63'd0, pred_hit_o}, {63'd0, e.hit});
                chk($sformatf("pred_target[%0d]", e.id), pred_target_o, e.tgt);
                chk($sformatf("pred_hist[%0d]", e.id), {57'd0, pred_hist_o}, {57'd0, e.hist});
            end
        end
    end

    initial begin
        rst = 1'b1;
        lookup_valid_i = 1'b0; lookup_pc_i = '0;
        update_valid_i = 1'b0; update_pc_i = '0; update_target_i = '0; update_hist_i = '0;

        // Basic train/lookup and hysteresis on PC 0x1000 (set 0, tag 8)
        add(0, 0, 0, 0,                      1, 64'h1000, 0, 64'h0, 7'h00);
        add(1, 64'h1000, 64'h8000, 0,        0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                      1, 64'h1000, 1, 64'h8000, 7'h00);
        add(1, 64'h1000, 64'h8000, 0,        0, 0, 0, 0, 0);
        add(1, 64'h1000, 64'h8000, 0,        0, 0, 0, 0, 0);
        add(1, 64'h1000, 64'h8000, 0,        0, 0, 0, 0, 0);
        add(1, 64'h1000, 64'h9000, 0,        0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                      1, 64'h1000, 1, 64'h8000, 7'h00);
        add(1, 64'h1000, 64'h9000, 0,        0, 0, 0, 0, 0);
        add(1, 64'h1000, 64'h9000, 0,        0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                      1, 64'h1000, 1, 64'h8000, 7'h00);
        add(1, 64'h1000, 64'h9000, 0,        0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                      1, 64'h1000, 1, 64'h9000, 7'h00);
        // Same-cycle update and lookup: old target now, new target next cycle
        add(1, 64'h1000, 64'h8000, 0,        0, 0, 0, 0, 0);
        add(1, 64'h1000, 64'h8000, 0,        1, 64'h1000, 1, 64'h9000, 7'h00);
        add(0, 0, 0, 0,                      1, 64'h1000, 1, 64'h8000, 7'h00);
        // Four tags aliasing into set 5, then a fifth tag
        add(1, 64'h10014, 64'hA000, 0,       0, 0, 0, 0, 0);
        add(1, 64'h20014, 64'hB000, 0,       0, 0, 0, 0, 0);
        add(1, 64'h30014, 64'hC000, 0,       0, 0, 0, 0, 0);
        add(1, 64'h40014, 64'hD000, 0,       0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                      1, 64'h10014, 1, 64'hA000, 7'h00);
        add(0, 0, 0, 0,                      1, 64'h20014, 1, 64'hB000, 7'h00);
        add(0, 0, 0, 0,                      1, 64'h30014, 1, 64'hC000, 7'h00);
        add(0, 0, 0, 0,                      1, 64'h40014, 1, 64'hD000, 7'h00);
        add(1, 64'h50014, 64'hE000, 0,       0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                      1, 64'h50014, 0, 64'h0, 7'h00);
        add(0, 0, 0, 0,                      1, 64'h10014, 1, 64'hA000, 7'h00);
        add(1, 64'h50014, 64'hE000, 0,       0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                      1, 64'h50014, 1, 64'hE000, 7'h00);
        add(0, 0, 0, 0,                      1, 64'h10014, 0, 64'h0, 7'h00);
        add(0, 0, 0, 0,                      1, 64'h20014, 1, 64'hB000, 7'h00);
        // History: target 0x104 sets hist to 0x41, then a shift to 0x02
        add(1, 64'h3000, 64'h104, 0,         1, 64'h3000, 0, 64'h0, 7'h00);
        add(0, 0, 0, 0,                      1, 64'h3000, 0, 64'h0, 7'h41);
        add(0, 0, 0, 0,                      1, 64'h3104, 1, 64'h104, 7'h41);
        add(1, 64'h1000, 64'h8000, 0,        0, 0, 0, 0, 0);
        add(0, 0, 0, 0,                      1, 64'h1000, 0, 64'h0, 7'h02);
        add(0, 0, 0, 0,                      1, 64'h1008, 1, 64'h8000, 7'h02);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_pred_valid", {63'd0, pred_valid_o}, 64'd0);
        chk("reset_pred_hit", {63'd0, pred_hit_o}, 64'd0);
        chk("reset_pred_target", pred_target_o, 64'd0);
        chk("reset_pred_hist", {57'd0, pred_hist_o}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
        idle();
        idle();
        idle();
        chk("sb_drained_main", 64'(sbq.size()), 64'd0);

        // Reset lands while a lookup result is pending
        begin
            vec_t v;
            v.uv = 1'b0; v.upc = '0; v.utgt = '0; v.uh = '0;
            v.lv = 1'b1; v.lpc = 64'h1000; v.ehit = 1'b0; v.etgt = '0; v.ehist = '0;
            @(posedge clk);
            #1;
            lookup_valid_i = 1'b1;
            lookup_pc_i    = 64'h1000;
            @(posedge clk);
            #1;
            rst = 1'b1;
            lookup_valid_i = 1'b0;
            #1;
            chk("midrst_pred_valid", {63'd0, pred_valid_o}, 64'd0);
            chk("midrst_pred_hit", {63'd0, pred_hit_o}, 64'd0);
            chk("midrst_pred_target", pred_target_o, 64'd0);
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
            idle();
            idle();
            drive(v);
            v.lpc = 64'h20014; drive(v);
            v.lpc = 64'h3000;  drive(v);
            v.lpc = 64'h50014; drive(v);
            idle();
            idle();
            idle();
        end
        chk("sb_drained_final", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
